// File: rtl/alu_con_flags.sv
// Registered 32-bit ALU (ADD/SUB/AND/OR) producing {N,Z,C,V} flags one cycle after operands.
// Optional sticky overflow output is built when ALU_STICKY_OVF_EN is defined.
module alu_con_flags #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       ALUControl,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       ALUFlags
`ifdef ALU_STICKY_OVF_EN
    ,
    output logic             sticky_v
`endif
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             is_arith;

    logic [WIDTH-1:0] out_d,   out_q;
    logic [3:0]       flags_d, flags_q;

    // One shared adder: SUB reuses it with B inverted and carry-in from ALUControl[0].
    always_comb begin
        is_arith = (ALUControl[1] == 1'b0);
        b_eff    = ALUControl[0] ? ~B : B;
        sum      = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, ALUControl[0]};
    end

    always_comb begin
        out_d   = '0;
        flags_d = 4'b0000;
        case (ALUControl)
            2'b00, 2'b01: out_d = sum[WIDTH-1:0];
            2'b10:        out_d = A & B;
            2'b11:        out_d = A | B;
            default:      out_d = '0;
        endcase
        flags_d[3] = out_d[WIDTH-1];
        flags_d[2] = (out_d == '0);
        flags_d[1] = is_arith & sum[WIDTH];
        flags_d[0] = is_arith & (A[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != A[WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            flags_q <= 4'b0000;
        end else begin
            out_q   <= out_d;
            flags_q <= flags_d;
        end
    end

    assign out      = out_q;
    assign ALUFlags = flags_q;

`ifdef ALU_STICKY_OVF_EN
    logic sticky_d, sticky_q;

    // Sets on the same edge the registered V goes high; only reset clears it.
    always_comb begin
        sticky_d = sticky_q | flags_d[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_v = sticky_q;
`endif

endmodule

// File: tb/tb_alu_con_flags.sv
// Scoreboard bench for alu_con_flags: driver queues hand-computed results, monitor checks them.
// Define ALU_STICKY_OVF_EN for both DUT and bench to also check sticky_v.
module tb_alu_con_flags;

    logic        clk;
    logic        rst_n;
    logic [31:0] a_i, b_i;
    logic [1:0]  ctl_i;
    logic [31:0] out_o;
    logic [3:0]  flags_o;
`ifdef ALU_STICKY_OVF_EN
    logic        sticky_o;
`endif

    typedef struct packed {
        logic [31:0] out;
        logic [3:0]  flags;
        logic        sticky;
    } exp_t;

    exp_t exp_q[$];
    logic issue;
    logic pend;
    logic exp_sticky;
    int   n_cmp;
    int   n_bad;

    alu_con_flags #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .A          (a_i),
        .B          (b_i),
        .ALUControl (ctl_i),
        .out        (out_o),
        .ALUFlags   (flags_o)
`ifdef ALU_STICKY_OVF_EN
        ,
        .sticky_v   (sticky_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    // Driver: operands applied at the falling edge, captured by the next rising edge.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] ctl,
                         input logic [31:0] e_out, input logic [3:0] e_flags);
        exp_t e;
        @(negedge clk);
        a_i   = a;
        b_i   = b;
        ctl_i = ctl;
        issue = 1'b1;
        exp_sticky = exp_sticky | e_flags[0];
        e.out    = e_out;
        e.flags  = e_flags;
        e.sticky = exp_sticky;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            issue = 1'b0;
            a_i   = $urandom;
            b_i   = $urandom;
            ctl_i = 2'($urandom_range(0, 3));
        end
    endtask

    always @(posedge clk) pend <= issue;

    // Monitor: one cycle after issue, the registered result must be on the outputs.
    always @(negedge clk) begin
        if (pend) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_underflow: got output with no expected entry");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check32("out", out_o, e.out);
                check4("flags", flags_o, e.flags);
`ifdef ALU_STICKY_OVF_EN
                check4("sticky_v", {3'b0, sticky_o}, {3'b0, e.sticky});
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        issue = 1'b0;
        pend  = 1'b0;
        exp_sticky = 1'b0;
        a_i   = 32'h1234_5678;
        b_i   = 32'h8765_4321;
        ctl_i = 2'b00;
        rst_n = 1'b0;
        #3;
        check32("reset_out", out_o, 32'h0);
        check4("reset_flags", flags_o, 4'b0000);
        @(posedge clk);
        #1;
        check32("reset_hold_out", out_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        //     A             B             op     out           NZCV
        do_op(32'h00000001, 32'h00000081, 2'b00, 32'h00000082, 4'b0000);
        do_op(32'h00000011, 32'h00000089, 2'b01, 32'hFFFFFF88, 4'b1000);
        do_op(32'h00000091, 32'h000000E9, 2'b10, 32'h00000081, 4'b0000);
        do_op(32'h00004011, 32'h00007E89, 2'b11, 32'h00007E99, 4'b0000);
        do_op(32'h7FFFFFFF, 32'h00000001, 2'b00, 32'h80000000, 4'b1001);
        do_op(32'h00000005, 32'h00000005, 2'b01, 32'h00000000, 4'b0110);
        do_op(32'hFFFFFFFF, 32'h00000001, 2'b00, 32'h00000000, 4'b0110);
        idle(2);
        do_op(32'h80000000, 32'h00000001, 2'b01, 32'h7FFFFFFF, 4'b0011);
        do_op(32'hFFFFFFFF, 32'h80000000, 2'b10, 32'h80000000, 4'b1000);
        do_op(32'h00000000, 32'h00000000, 2'b11, 32'h00000000, 4'b0100);
        do_op(32'h80000000, 32'h80000000, 2'b00, 32'h00000000, 4'b0111);
        do_op(32'h00000000, 32'h00000000, 2'b01, 32'h00000000, 4'b0110);
        do_op(32'h00000010, 32'h00000020, 2'b00, 32'h00000030, 4'b0000);
        do_op(32'hFFFFFFF0, 32'h0000000F, 2'b11, 32'hFFFFFFFF, 4'b1000);
        idle(3);

        // Asynchronous reset between edges while a nonzero result is held.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_sticky = 1'b0;
        #1;
        check32("async_rst_out", out_o, 32'h0);
        check4("async_rst_flags", flags_o, 4'b0000);
`ifdef ALU_STICKY_OVF_EN
        check4("async_rst_sticky", {3'b0, sticky_o}, 4'b0000);
`endif
        a_i   = 32'h7FFFFFFF;
        b_i   = 32'h00000001;
        ctl_i = 2'b00;
        @(posedge clk);
        #1;
        check32("rst_low_out", out_o, 32'h0);
        check4("rst_low_flags", flags_o, 4'b0000);
        #2;
        rst_n = 1'b1;

        do_op(32'h00000002, 32'h00000003, 2'b00, 32'h00000005, 4'b0000);
        do_op(32'h00000003, 32'h00000002, 2'b01, 32'h00000001, 4'b0010);
        idle(3);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
